// File: rtl/pwl_activation_stream_if.sv
// Stream and configuration bundle for pwl_activation_stream.
// The master side drives samples and table writes; the slave side is the activation unit.
interface pwl_activation_stream_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [DATA_W-1:0] cfg_bp;
  logic [2:0]        cfg_code;
  logic [DATA_W-1:0] cfg_bias;

  modport master (
    output in_valid, in_x, out_ready, cfg_we, cfg_idx, cfg_bp, cfg_code, cfg_bias,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, out_ready, cfg_we, cfg_idx, cfg_bp, cfg_code, cfg_bias,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/pwl_activation_stream.sv
// Piecewise-linear activation: y = sat(((x - bp[k]) >>> code[k]) + bias[k]),
// segment k picked from a runtime-loaded breakpoint table, 3-stage elastic pipeline.
module pwl_activation_stream #(
  parameter int DATA_W = 16,
  parameter int SEG_N  = 32,
  parameter int IDX_W  = 5
) (
  input logic                     clk,
  input logic                     rst,
  pwl_activation_stream_if.slave  bus
);
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] bp_r   [SEG_N];
  logic [2:0]        code_r [SEG_N];
  logic [DATA_W-1:0] bias_r [SEG_N];

  logic              wr_pend_r;
  logic [IDX_W-1:0]  wr_idx_r;
  logic [DATA_W-1:0] wr_bp_r;
  logic [2:0]        wr_code_r;
  logic [DATA_W-1:0] wr_bias_r;

  logic              v1_r, v2_r, v3_r;
  logic [DATA_W-1:0] x1_r, x2_r, bp2_r, bias2_r, y_r;
  logic [2:0]        code2_r;

  logic                     ready1_s, ready2_s, ready3_s;
  logic [IDX_W-1:0]         k_s;
  logic signed [DATA_W:0]   d_s;
  logic signed [DATA_W:0]   t_s;
  logic signed [DATA_W+1:0] s_s;
  logic [DATA_W-1:0]        y_s;

  // Stage readiness: a stage can load when it is empty or the stage after it can load.
  always_comb begin
    ready3_s = ~v3_r | bus.out_ready;
    ready2_s = ~v2_r | ready3_s;
    ready1_s = ~v1_r | ready2_s;
  end

  assign bus.in_ready  = ready1_s;
  assign bus.out_valid = v3_r;
  assign bus.out_y     = y_r;

  // Capture a table write; it is committed one cycle later so that the sample
  // accepted alongside cfg_we still reads the old entry when it reaches stage 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_pend_r <= 1'b0;
      wr_idx_r  <= {IDX_W{1'b0}};
      wr_bp_r   <= ZERO_D;
      wr_code_r <= 3'd7;
      wr_bias_r <= ZERO_D;
    end else begin
      wr_pend_r <= bus.cfg_we;
      if (bus.cfg_we) begin
        wr_idx_r  <= bus.cfg_idx;
        wr_bp_r   <= bus.cfg_bp;
        wr_code_r <= bus.cfg_code;
        wr_bias_r <= bus.cfg_bias;
      end
    end
  end

  // Segment table; reset contents give a zero-slope, zero-bias curve.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SEG_N; i++) begin
        bp_r[i]   <= ZERO_D;
        code_r[i] <= 3'd7;
        bias_r[i] <= ZERO_D;
      end
    end else if (wr_pend_r) begin
      bp_r[wr_idx_r]   <= wr_bp_r;
      code_r[wr_idx_r] <= wr_code_r;
      bias_r[wr_idx_r] <= wr_bias_r;
    end
  end

  // Highest segment whose breakpoint the sample reaches; bp[0] is only a base.
  always_comb begin
    k_s = {IDX_W{1'b0}};
    for (int i = 1; i < SEG_N; i++) begin
      if ($signed(x1_r) >= $signed(bp_r[i])) begin
        k_s = IDX_W'(i);
      end else begin
        k_s = k_s;
      end
    end
  end

  // Offset, shift, bias and saturate; one extra bit for d and two for s avoid wrap.
  always_comb begin
    d_s = {x2_r[DATA_W-1], x2_r} - {bp2_r[DATA_W-1], bp2_r};
    if (code2_r == 3'd7) begin
      t_s = {(DATA_W+1){1'b0}};
    end else begin
      t_s = d_s >>> code2_r;
    end
    s_s = {t_s[DATA_W], t_s} + {{2{bias2_r[DATA_W-1]}}, bias2_r};
    if ((s_s[DATA_W+1:DATA_W-1] == 3'b000) || (s_s[DATA_W+1:DATA_W-1] == 3'b111)) begin
      y_s = s_s[DATA_W-1:0];
    end else if (s_s[DATA_W+1]) begin
      y_s = SAT_MIN;
    end else begin
      y_s = SAT_MAX;
    end
  end

  // Pipeline registers; payload only loads alongside a valid sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      v3_r    <= 1'b0;
      x1_r    <= ZERO_D;
      x2_r    <= ZERO_D;
      bp2_r   <= ZERO_D;
      code2_r <= 3'd7;
      bias2_r <= ZERO_D;
      y_r     <= ZERO_D;
    end else begin
      if (ready1_s) begin
        v1_r <= bus.in_valid;
        if (bus.in_valid) begin
          x1_r <= bus.in_x;
        end
      end
      if (ready2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          x2_r    <= x1_r;
          bp2_r   <= bp_r[k_s];
          code2_r <= code_r[k_s];
          bias2_r <= bias_r[k_s];
        end
      end
      if (ready3_s) begin
        v3_r <= v2_r;
        if (v2_r) begin
          y_r <= y_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwl_activation_stream.sv
// Scoreboarded random and directed bench for pwl_activation_stream against an
// integer-arithmetic model of the segment table.
module tb_pwl_activation_stream;
  localparam int DATA_W = 16;
  localparam int SEG_N  = 32;
  localparam int IDX_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwl_activation_stream_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus();

  pwl_activation_stream #(.DATA_W(DATA_W), .SEG_N(SEG_N), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [15:0] m_bp   [SEG_N];
  int                 m_code [SEG_N];
  logic signed [15:0] m_bias [SEG_N];

  logic [15:0] exp_q[$];
  int          acc_q[$];
  int checks = 0, passed = 0, cyc = 0, acc_cnt = 0;
  bit strict_lat = 1'b0;
  logic hold_v = 1'b0;
  logic [15:0] hold_y, e_y;
  int a_cyc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < SEG_N; i++) begin
      m_bp[i] = 16'sd0; m_code[i] = 7; m_bias[i] = 16'sd0;
    end
  endfunction

  function automatic logic [15:0] ref_y(logic [15:0] x);
    int k, d, t, s;
    k = 0;
    for (int i = 1; i < SEG_N; i++)
      if ($signed(x) >= m_bp[i]) k = i;
    if (m_code[k] == 7) t = 0;
    else begin
      d = int'($signed(x)) - int'(m_bp[k]);
      t = d >>> m_code[k];
    end
    s = t + int'(m_bias[k]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor first (pop/compare), then record acceptances and table writes.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete(); acc_q.delete(); model_reset(); hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_y", 32'(bus.out_y), 32'(hold_y));
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_y = bus.out_y;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_out: got %h expected no output", bus.out_y);
        end else begin
          e_y = exp_q.pop_front();
          a_cyc = acc_q.pop_front();
          chk("out_y", 32'(bus.out_y), 32'(e_y));
          if (strict_lat) chk("latency", 32'(cyc - a_cyc), 32'd3);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_y(bus.in_x));
        acc_q.push_back(cyc);
        acc_cnt++;
      end
      if (bus.cfg_we) begin
        m_bp[bus.cfg_idx]   = $signed(bus.cfg_bp);
        m_code[bus.cfg_idx] = int'(bus.cfg_code);
        m_bias[bus.cfg_idx] = $signed(bus.cfg_bias);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(logic [15:0] x);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_x = x;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        break;
      end
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg(int idx, logic [15:0] bp, logic [2:0] code, logic [15:0] bias);
    bus.cfg_we = 1'b1; bus.cfg_idx = 5'(idx); bus.cfg_bp = bp;
    bus.cfg_code = code; bus.cfg_bias = bias;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  task automatic seg1_table();
    cfg(0, 16'h0000, 3'd7, 16'h0000);
    cfg(1, 16'h0000, 3'd1, 16'h0100);
    for (int i = 2; i < SEG_N; i++) cfg(i, 16'h7F00, 3'd7, 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bit acc;
    bus.in_valid = 1'b0; bus.in_x = 16'h0000; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = 5'd0; bus.cfg_bp = 16'h0000;
    bus.cfg_code = 3'd0; bus.cfg_bias = 16'h0000;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_y", 32'(bus.out_y), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Reset table and latency.
    strict_lat = 1'b1;
    send(16'h1234);
    drain();

    // Shift slope in seg1, negative input falls to seg0.
    seg1_table();
    send(16'h0080);
    send(16'hFF00);
    drain();

    // Saturation both ways.
    for (int i = 0; i < SEG_N; i++) cfg(i, 16'h0000, 3'd0, 16'h7FF0);
    send(16'h7FFF);
    drain();
    for (int i = 0; i < SEG_N; i++) cfg(i, 16'h0000, 3'd0, 16'h8000);
    send(16'h8000);
    drain();

    // Backpressure: three samples buffer, then in_ready drops.
    seg1_table();
    strict_lat = 1'b0;
    bus.out_ready = 1'b0;
    base = acc_cnt;
    bus.in_valid = 1'b1; bus.in_x = 16'($urandom);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) bus.in_x = 16'($urandom);
    end
    @(negedge clk);
    chk("bp_accepted", 32'(acc_cnt - base), 32'd3);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) send(16'($urandom));
    drain();

    // Table rewrite mid-stream at iteration 5.
    strict_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1; bus.in_x = 16'h0080;
      bus.cfg_we = (i == 5); bus.cfg_idx = 5'd1; bus.cfg_bp = 16'h0000;
      bus.cfg_code = 3'd1; bus.cfg_bias = 16'h0200;
      @(negedge clk);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
    drain();

    // Random tables and random traffic with random backpressure.
    strict_lat = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < SEG_N; i++)
        cfg(i, 16'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
      acc = 1'b1;
      for (int c = 0; c < 250; c++) begin
        if (!bus.in_valid || acc) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          case ($urandom_range(0, 5))
            0: bus.in_x = 16'h7FFF;
            1: bus.in_x = 16'h8000;
            default: bus.in_x = 16'($urandom);
          endcase
        end
        bus.out_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        step();
      end
      bus.in_valid = 1'b0;
      drain();
    end

    // Reset with three samples in flight.
    seg1_table();
    send(16'h0080);
    send(16'h0100);
    send(16'h0200);
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_y", 32'(bus.out_y), 32'd0);
    step();
    repeat (5) step();
    strict_lat = 1'b1;
    send(16'h0080);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
